// File: rtl/alu.sv
// 4-bit ALU with registered BCD result display, carry and overflow flags.
// Optional build macro: ALU_SIGNED_BCD_EN (signed magnitude display for SUB).
//
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   A, B     : 4-bit operands
//   CarryIN  : carry-in for ADD, borrow-in for SUB
//   opCodeA  : operation select
//   CarryOUT : carry, borrow or shifted-out bit (registered)
//   overflow : signed two's-complement overflow (registered)
//   bcd      : hundreds/sign, tens, units BCD digits (registered)
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  A,
  input  logic [3:0]  B,
  input  logic        CarryIN,
  input  logic [2:0]  opCodeA,
  output logic        CarryOUT,
  output logic        overflow,
  output logic [11:0] bcd
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SUB = 3'b111;

  logic [4:0]  sum;
  logic [4:0]  diff;
  logic [3:0]  r;
  logic        c;
  logic        ov;
  logic [4:0]  v;
  logic        neg;
  logic [3:0]  tens;
  logic [3:0]  units;
  logic [11:0] bcd_d;

  // Extended to 5 bits: sum[4] is the carry, diff[4] the unsigned borrow.
  assign sum  = {1'b0, A} + {1'b0, B} + {4'b0, CarryIN};
  assign diff = {1'b0, A} - {1'b0, B} - {4'b0, CarryIN};

  always_comb begin
    r   = 4'h0;
    c   = 1'b0;
    ov  = 1'b0;
    v   = 5'd0;
    neg = 1'b0;
    unique case (opCodeA)
      OP_AND: r = A & B;
      OP_OR:  r = A | B;
      OP_XOR: r = A ^ B;
      OP_ADD: begin
        r  = sum[3:0];
        c  = sum[4];
        ov = (A[3] == B[3]) && (r[3] != A[3]);
      end
      OP_NOT: r = ~A;
      OP_SHL: begin
        r = {A[2:0], 1'b0};
        c = A[3];
      end
      OP_SHR: begin
        r = {1'b0, A[3:1]};
        c = A[0];
      end
      OP_SUB: begin
        r  = diff[3:0];
        c  = diff[4];
        ov = (A[3] != B[3]) && (r[3] != A[3]);
      end
      default: r = 4'h0;
    endcase

    if (opCodeA == OP_ADD) begin
      v = {c, r};
    end else begin
      v = {1'b0, r};
    end

`ifdef ALU_SIGNED_BCD_EN
    // A borrow means the true difference is negative (-1..-16);
    // show its magnitude with the minus code in the hundreds digit.
    if (opCodeA == OP_SUB && c) begin
      v   = 5'd0 - diff;
      neg = 1'b1;
    end
`endif
  end

  // Double-dabble over the 5-bit value; tens never exceeds 3.
  always_comb begin
    logic [12:0] sh;
    sh = {8'h00, v};
    for (int i = 0; i < 5; i++) begin
      if (sh[8:5] >= 4'd5) begin
        sh[8:5] = sh[8:5] + 4'd3;
      end
      if (sh[12:9] >= 4'd5) begin
        sh[12:9] = sh[12:9] + 4'd3;
      end
      sh = {sh[11:0], 1'b0};
    end
    tens  = sh[12:9];
    units = sh[8:5];
  end

  assign bcd_d = {(neg ? 4'hF : 4'h0), tens, units};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      CarryOUT <= 1'b0;
      overflow <= 1'b0;
      bcd      <= 12'h000;
    end else begin
      CarryOUT <= c;
      overflow <= ov;
      bcd      <= bcd_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard testbench for alu: directed vectors with hand-computed
// expectations, queued at issue and checked by a separate monitor.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        cin;
  logic [2:0]  op;
  logic        carry_out;
  logic        ovf;
  logic [11:0] bcd;

  typedef struct packed {
    logic [11:0] bcd;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_bad;

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .A        (a),
    .B        (b),
    .CarryIN  (cin),
    .opCodeA  (op),
    .CarryOUT (carry_out),
    .overflow (ovf),
    .bcd      (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input exp_t e);
    n_vec++;
    if (bcd !== e.bcd || carry_out !== e.co || ovf !== e.ov) begin
      n_bad++;
      $display("FAIL %s: got bcd=%h co=%b ov=%b, want bcd=%h co=%b ov=%b",
               name, bcd, carry_out, ovf, e.bcd, e.co, e.ov);
    end
  endtask

  // Monitor: result of an edge is visible 1 time unit after it.
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      check("scoreboard", exp_q.pop_front());
    end
  end

  task automatic apply(input logic [2:0] o, input logic [3:0] x,
                       input logic [3:0] y, input logic ci,
                       input logic [11:0] eb, input logic eco,
                       input logic eov);
    @(negedge clk);
    op  = o;
    a   = x;
    b   = y;
    cin = ci;
    exp_q.push_back('{bcd: eb, co: eco, ov: eov});
  endtask

  logic [11:0] sub_neg15;
  logic [11:0] sub_neg9;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    op  = 3'b011;
    a   = 4'hF;
    b   = 4'hF;
    cin = 1'b1;
`ifdef ALU_SIGNED_BCD_EN
    sub_neg15 = 12'hF15;
    sub_neg9  = 12'hF09;
`else
    sub_neg15 = 12'h001;
    sub_neg9  = 12'h007;
`endif
    #2;
    check("reset_async", '{bcd: 12'h000, co: 1'b0, ov: 1'b0});
    @(posedge clk);
    #1;
    check("reset_hold", '{bcd: 12'h000, co: 1'b0, ov: 1'b0});
    @(negedge clk);
    rst = 1'b0;

    apply(3'b011, 4'hF, 4'hF, 1'b1, 12'h031, 1'b1, 1'b0);
    apply(3'b011, 4'h7, 4'h7, 1'b1, 12'h015, 1'b0, 1'b1);
    apply(3'b011, 4'h8, 4'h8, 1'b0, 12'h016, 1'b1, 1'b1);
    apply(3'b111, 4'h0, 4'hF, 1'b0, sub_neg15, 1'b1, 1'b0);
    apply(3'b111, 4'h7, 4'hF, 1'b1, sub_neg9, 1'b1, 1'b0);
    apply(3'b111, 4'hF, 4'h0, 1'b0, 12'h015, 1'b0, 1'b0);
    apply(3'b111, 4'h8, 4'h1, 1'b0, 12'h007, 1'b0, 1'b1);
    apply(3'b010, 4'h7, 4'hF, 1'b1, 12'h008, 1'b0, 1'b0);
    apply(3'b000, 4'hC, 4'h6, 1'b1, 12'h004, 1'b0, 1'b0);
    apply(3'b001, 4'h9, 4'h4, 1'b0, 12'h013, 1'b0, 1'b0);
    apply(3'b100, 4'h5, 4'h0, 1'b1, 12'h010, 1'b0, 1'b0);
    apply(3'b101, 4'h9, 4'h0, 1'b0, 12'h002, 1'b1, 1'b0);
    apply(3'b110, 4'h9, 4'h0, 1'b0, 12'h004, 1'b1, 1'b0);
    apply(3'b010, 4'hF, 4'hF, 1'b0, 12'h000, 1'b0, 1'b0);
    apply(3'b011, 4'h7, 4'h7, 1'b1, 12'h015, 1'b0, 1'b1);

    // Pending ADD discarded by reset raised between edges.
    @(negedge clk);
    op  = 3'b011;
    a   = 4'hF;
    b   = 4'hF;
    cin = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("reset_midstream", '{bcd: 12'h000, co: 1'b0, ov: 1'b0});
    @(posedge clk);
    #1;
    check("reset_midhold", '{bcd: 12'h000, co: 1'b0, ov: 1'b0});
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{bcd: 12'h031, co: 1'b1, ov: 1'b0});

    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
